// File: rtl/fetch_sequencer.sv
// fetch_sequencer: dual-issue PC sequencer and fetch-packet register.
// Drives two fetch PCs into a combinational reader, captures the returned
// instruction pair and hands it to decode over valid/ready.
module fetch_sequencer #(
  parameter int unsigned          PC_SIZE    = 32,
  parameter int unsigned          INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [PC_SIZE-1:0]    pc0_o,
  output logic [PC_SIZE-1:0]    pc1_o,
  input  logic [INSTR_SIZE-1:0] instr0_i,
  input  logic [INSTR_SIZE-1:0] instr1_i,
  input  logic                  done_i,
  input  logic                  redirect_valid_i,
  input  logic [PC_SIZE-1:0]    redirect_pc_i,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [PC_SIZE-1:0]    fetch_pc_o,
  output logic [INSTR_SIZE-1:0] fetch_instr0_o,
  output logic [INSTR_SIZE-1:0] fetch_instr1_o,
  output logic                  halted_o,
  output logic [31:0]           packet_count_o
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PC_SIZE-1:0]      pc0_q, pc0_d;
  logic [PC_SIZE-1:0]      pc1_q, pc1_d;
  logic                    valid_q, valid_d;
  logic [PC_SIZE-1:0]      fpc_q, fpc_d;
  logic [INSTR_SIZE-1:0]   i0_q, i0_d;
  logic [INSTR_SIZE-1:0]   i1_q, i1_d;
  logic                    halted_q, halted_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hs;
  logic [PC_SIZE-1:0]      redirect_target;

  assign hs              = valid_q & fetch_ready_i;
  assign redirect_target = {redirect_pc_i[PC_SIZE-1:2], 2'b00};

  // Next-state, PC advance and packet capture; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc0_d   = pc0_q;
    valid_d = valid_q;
    fpc_d   = fpc_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    cnt_d   = hs ? cnt_q + CNT_W'(1) : cnt_q;

    if (hs) valid_d = 1'b0;

    if (redirect_valid_i) begin
      valid_d = 1'b0;
      pc0_d   = redirect_target;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (done_i) begin
            state_d = DRAIN;
          end else if (!valid_q || fetch_ready_i) begin
            valid_d = 1'b1;
            fpc_d   = pc0_q;
            i0_d    = instr0_i;
            i1_d    = instr1_i;
            pc0_d   = pc0_q + PC_SIZE'(8);
          end
        end
        DRAIN: begin
          if (!valid_q || hs) state_d = HALT;
        end
        HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end

    pc1_d    = pc0_d + PC_SIZE'(4);
    halted_d = (state_d == HALT);
  end

  // State, PC pair, output packet and handshake counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FETCH;
      pc0_q    <= RESET_PC;
      pc1_q    <= RESET_PC + PC_SIZE'(4);
      valid_q  <= 1'b0;
      fpc_q    <= '0;
      i0_q     <= '0;
      i1_q     <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      valid_q  <= valid_d;
      fpc_q    <= fpc_d;
      i0_q     <= i0_d;
      i1_q     <= i1_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc0_o          = pc0_q;
  assign pc1_o          = pc1_q;
  assign fetch_valid_o  = valid_q;
  assign fetch_pc_o     = fpc_q;
  assign fetch_instr0_o = i0_q;
  assign fetch_instr1_o = i1_q;
  assign halted_o       = halted_q;
  assign packet_count_o = cnt_q;

endmodule
